axi_xbar_cfg_ctrl: RTL
======================

# axi_xbar_cfg_ctrl

Run-time reconfiguration controller for the default-master-port settings of `axi_xbar`. It sits on the AW/AR valid/ready lines between the upstream masters and the crossbar slave ports, and tracks outstanding write and read transactions per port. On a configuration request it stalls new address beats, drains all in-flight transactions, and then atomically updates `en_default_mst_port`/`default_mst_port`. The crossbar's default-port settings therefore never change while an Ax beat is unserved or while responses are still in flight.

## Interface
- `NoSlvPorts`, default 2: number of crossbar slave ports.
- `NoMstPorts`, default 2: number of crossbar master ports; `IdxW = $clog2(NoMstPorts)`.
- `MaxTrans`, default 8: outstanding-transaction limit per port and direction; counter width `CntW = $clog2(MaxTrans+1)`.
- `RstEnDefault`, default '0: reset value of `en_default_mst_port_o` (NoSlvPorts bits).
- `RstDefaultPort`, default '0: reset value of `default_mst_port_o`.
- `TimeoutCycles`, default 1024: drain timeout; used only with the macro below.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `up_aw_valid_i` in N: upstream AW valid.
- `up_aw_ready_o` out N: upstream AW ready.
- `up_aw_atop_r_i` in N: AW carries an ATOP with an R response (atop[5]).
- `xbar_aw_valid_o` out N: gated AW valid to the crossbar.
- `xbar_aw_ready_i` in N: crossbar AW ready.
- `up_ar_valid_i`, `up_ar_ready_o`, `xbar_ar_valid_o`, `xbar_ar_ready_i`: AR equivalents of the four AW signals above, N bits each.
- `b_valid_i`, `b_ready_i` in N: monitored B handshake per slave port.
- `r_valid_i`, `r_ready_i`, `r_last_i` in N: monitored R handshake per slave port.
- `cfg_valid_i` in 1: new configuration request.
- `cfg_ready_o` out 1: request accepted.
- `cfg_en_default_i` in N: requested enables.
- `cfg_default_port_i` in N×IdxW: requested default ports.
- `en_default_mst_port_o` out N: enable output to the crossbar.
- `default_mst_port_o` out N×IdxW: default-port output to the crossbar.
- `busy_o` out 1: reconfiguration in progress.
- `done_o` out 1: one-cycle pulse when the new configuration is applied.
- `err_o` out 1: sticky error flag.

## Operation
- FSM states: IDLE, DRAIN, APPLY.
- IDLE: `cfg_ready_o`=1. When `cfg_valid_i`=1, latch `cfg_*` into shadow registers and go to DRAIN.
- DRAIN: `busy_o`=1 and `stall`=1. Go to APPLY when every counter is 0 and no `aw_pend`/`ar_pend` bit is set.
- APPLY: one cycle. Copy the shadow registers to the outputs at the end of the cycle, pulse `done_o`, return to IDLE.
- `aw_pend[i]` register: `xbar_aw_valid_o[i] & ~xbar_aw_ready_i[i]`. `ar_pend` is the same for AR.
- Gating: `xbar_aw_valid_o[i] = up_aw_valid_i[i] & ~blk_aw[i]` and `up_aw_ready_o[i] = xbar_aw_ready_i[i] & ~blk_aw[i]`.
  - `blk_aw[i] = ~aw_pend[i] & (stall | wcnt[i]==MaxTrans | (up_aw_atop_r_i[i] & rcnt[i]==MaxTrans))`.
  - A valid already presented is never withdrawn.
  - AR gating is the same, using `rcnt`.
- `wcnt[i]`: +1 on an AW handshake, −1 on a B handshake.
- `rcnt[i]`: +1 on an AR handshake, and also on an AW handshake with `up_aw_atop_r_i`; −1 on an R handshake with `r_last_i`.
- Simultaneous increment and decrement leave the counter unchanged.
- An AW handshake with `up_aw_atop_r_i` while `rcnt` is also decremented leaves `rcnt` unchanged.
- A decrement at count 0 holds the counter at 0 and sets `err_o`. `err_o` is cleared only by reset.
- An increment at `MaxTrans` can only come from a pending beat; saturate the counter and set `err_o`.
- `cfg_valid_i` while busy is ignored until the FSM returns to IDLE; `cfg_ready_o`=0 during that time.

## Timing
- Reset values: state=IDLE, counters=0, pend=0, `en_default_mst_port_o`=`RstEnDefault`, `default_mst_port_o`=`RstDefaultPort`, `busy_o`=0, `done_o`=0, `err_o`=0, `cfg_ready_o`=1.
- Gating is combinational: zero added latency on valid/ready.
- Request accepted in cycle t:
  - `stall`=1 from t+1.
  - With no traffic outstanding, APPLY is in t+2.
  - Outputs are updated and `done_o` is seen in t+2 for the pulse and from t+3 for the outputs.
  - Gating is released from t+3.
- Reset mid-drain discards the shadow registers and restores the reset values.

## Configuration
- `AXI_XBAR_CFG_CTRL_TIMEOUT_EN` defined:
  - A DRAIN cycle counter runs. After `TimeoutCycles` cycles in DRAIN, return to IDLE without applying and set `err_o`.
  - `done_o` does not pulse in this case.
- Macro undefined: DRAIN waits indefinitely and `TimeoutCycles` is unused.

## Test plan
- Idle request: `cfg_en_default_i`=2'b01 and `cfg_default_port_i[0]`=1 accepted at t, no traffic → `done_o` at t+2; outputs 2'b01 and port0=1 from t+3.
- Drain: 3 AWs on port 0 outstanding, request issued → AW/AR ready=0 on new beats; B handshakes at t+5, t+9, t+12 → `done_o` at t+14.
- Pending beat: port 1 AR valid, ready=0 when the request arrives → `xbar_ar_valid_o[1]` stays 1 until ready, then blocks; apply only after R last.
- Limit: `MaxTrans` AWs on port 0 with no B → next AW blocked; one B → the AW passes the next cycle.
- Error: B handshake with `wcnt`=0 → `err_o`=1 and persists; with the macro, no B for 1024 cycles in DRAIN → IDLE, `err_o`=1, outputs unchanged.
- Reset asserted during DRAIN → all outputs at reset values in the same cycle; gating released.

Source files
------------

// File: rtl/axi_xbar_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// axi_xbar_cfg_ctrl
//
// Run-time reconfiguration controller for the default-master-port settings of
// axi_xbar. It sits on the AW/AR valid/ready lines between the upstream
// masters and the crossbar slave ports, counts outstanding write and read
// transactions per slave port, and on a configuration request stalls new
// address beats, waits until everything in flight has completed, and then
// updates en_default_mst_port_o / default_mst_port_o in a single cycle.
//
// Optional feature (compile-time macro):
//   AXI_XBAR_CFG_CTRL_TIMEOUT_EN - bounds the drain phase to TimeoutCycles
//   cycles. On expiry the request is dropped (no apply, no done_o pulse) and
//   err_o is set. Without the macro the drain waits indefinitely.
//
// Ports (N = NoSlvPorts, IdxW = $clog2(NoMstPorts)):
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   up_aw_valid_i  [N]       upstream AW valid
//   up_aw_ready_o  [N]       upstream AW ready (gated)
//   up_aw_atop_r_i [N]       AW carries an ATOP that also produces R beats
//   xbar_aw_valid_o[N]       AW valid to the crossbar (gated)
//   xbar_aw_ready_i[N]       AW ready from the crossbar
//   up_ar_valid_i, up_ar_ready_o, xbar_ar_valid_o, xbar_ar_ready_i [N]
//                            AR equivalents of the four AW signals
//   b_valid_i, b_ready_i [N] monitored B handshake
//   r_valid_i, r_ready_i, r_last_i [N]  monitored R handshake
//   cfg_valid_i / cfg_ready_o            configuration request handshake
//   cfg_en_default_i   [N]               requested enables
//   cfg_default_port_i [N*IdxW]          requested default ports
//   en_default_mst_port_o [N]            applied enables
//   default_mst_port_o    [N*IdxW]       applied default ports
//   busy_o                               reconfiguration in progress
//   done_o                               one-cycle pulse on apply
//   err_o                                sticky error flag
// ---------------------------------------------------------------------------
module axi_xbar_cfg_ctrl #(
    parameter int unsigned NoSlvPorts    = 2,
    parameter int unsigned NoMstPorts    = 2,
    parameter int unsigned MaxTrans      = 8,
    parameter logic [NoSlvPorts-1:0] RstEnDefault = '0,
    parameter logic [NoSlvPorts*((NoMstPorts > 1) ? $clog2(NoMstPorts) : 1)-1:0]
                           RstDefaultPort = '0,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [NoSlvPorts-1:0] up_aw_valid_i,
    output logic [NoSlvPorts-1:0] up_aw_ready_o,
    input  logic [NoSlvPorts-1:0] up_aw_atop_r_i,
    output logic [NoSlvPorts-1:0] xbar_aw_valid_o,
    input  logic [NoSlvPorts-1:0] xbar_aw_ready_i,

    input  logic [NoSlvPorts-1:0] up_ar_valid_i,
    output logic [NoSlvPorts-1:0] up_ar_ready_o,
    output logic [NoSlvPorts-1:0] xbar_ar_valid_o,
    input  logic [NoSlvPorts-1:0] xbar_ar_ready_i,

    input  logic [NoSlvPorts-1:0] b_valid_i,
    input  logic [NoSlvPorts-1:0] b_ready_i,
    input  logic [NoSlvPorts-1:0] r_valid_i,
    input  logic [NoSlvPorts-1:0] r_ready_i,
    input  logic [NoSlvPorts-1:0] r_last_i,

    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [NoSlvPorts-1:0] cfg_en_default_i,
    input  logic [NoSlvPorts*((NoMstPorts > 1) ? $clog2(NoMstPorts) : 1)-1:0]
                                  cfg_default_port_i,

    output logic [NoSlvPorts-1:0] en_default_mst_port_o,
    output logic [NoSlvPorts*((NoMstPorts > 1) ? $clog2(NoMstPorts) : 1)-1:0]
                                  default_mst_port_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);
    localparam logic [CntW+1:0] CntLim = (CntW + 2)'(MaxTrans);
    localparam logic [CntW+1:0] CntOne = (CntW + 2)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StApply
    } state_e;

    typedef struct packed {
        logic [CntW-1:0] cnt;
        logic            err;
    } cnt_upd_t;

    // Next value of one outstanding counter. inc may be 2 when an AR and an
    // R-producing ATOP are accepted in the same cycle. Underflow holds at 0,
    // overflow saturates at MaxTrans; both raise the error flag.
    function automatic cnt_upd_t cnt_update(input logic [CntW-1:0] cnt,
                                            input logic [1:0]      inc,
                                            input logic            dec);
        cnt_upd_t        res;
        logic [CntW+1:0] sum;
        sum     = {2'b00, cnt} + {{CntW{1'b0}}, inc};
        res.err = 1'b0;
        if (dec) begin
            if (sum == '0) begin
                res.err = 1'b1;
            end else begin
                sum = sum - CntOne;
            end
        end
        if (sum > CntLim) begin
            sum     = CntLim;
            res.err = 1'b1;
        end
        res.cnt = sum[CntW-1:0];
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                       state_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
    logic                         cfg_ready_q;
    logic [NoSlvPorts-1:0]        shadow_en_q;
    logic [NoSlvPorts*IdxW-1:0]   shadow_port_q;
    logic [NoSlvPorts-1:0]        en_q;
    logic [NoSlvPorts*IdxW-1:0]   port_q;

    logic [CntW-1:0]              wcnt_q [NoSlvPorts];
    logic [CntW-1:0]              rcnt_q [NoSlvPorts];
    logic [CntW-1:0]              wcnt_d [NoSlvPorts];
    logic [CntW-1:0]              rcnt_d [NoSlvPorts];
    logic [NoSlvPorts-1:0]        aw_pend_q;
    logic [NoSlvPorts-1:0]        ar_pend_q;

    logic                         stall;
    logic [NoSlvPorts-1:0]        blk_aw;
    logic [NoSlvPorts-1:0]        blk_ar;
    logic [NoSlvPorts-1:0]        aw_hs;
    logic [NoSlvPorts-1:0]        ar_hs;
    logic [NoSlvPorts-1:0]        b_hs;
    logic [NoSlvPorts-1:0]        r_last_hs;
    logic                         cnt_err;
    logic                         drained;

    // Address beats are held back for the whole reconfiguration, including
    // the apply cycle, so nothing new is routed with half-updated settings.
    assign stall = busy_q;

    // -----------------------------------------------------------------------
    // Valid/ready gating
    // -----------------------------------------------------------------------
    // A beat that was already presented to the crossbar and not yet accepted
    // (pend) is never blocked: withdrawing a valid would violate AXI.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        blk_aw = '0;
        blk_ar = '0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            blk_aw[i] = ~aw_pend_q[i] &
                        (stall | (wcnt_q[i] == MaxCnt) |
                         (up_aw_atop_r_i[i] & (rcnt_q[i] == MaxCnt)));
            blk_ar[i] = ~ar_pend_q[i] & (stall | (rcnt_q[i] == MaxCnt));
        end
    end

    assign xbar_aw_valid_o = up_aw_valid_i   & ~blk_aw;
    assign up_aw_ready_o   = xbar_aw_ready_i & ~blk_aw;
    assign xbar_ar_valid_o = up_ar_valid_i   & ~blk_ar;
    assign up_ar_ready_o   = xbar_ar_ready_i & ~blk_ar;

    assign aw_hs     = xbar_aw_valid_o & xbar_aw_ready_i;
    assign ar_hs     = xbar_ar_valid_o & xbar_ar_ready_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

    // -----------------------------------------------------------------------
    // Outstanding counters
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_upd_t w_upd;
        cnt_upd_t r_upd;
        w_upd   = '0;
        r_upd   = '0;
        cnt_err = 1'b0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            w_upd = cnt_update(wcnt_q[i], {1'b0, aw_hs[i]}, b_hs[i]);
            // An R-producing ATOP occupies a read slot as well as a write slot.
            r_upd = cnt_update(rcnt_q[i],
                               {1'b0, ar_hs[i]} + {1'b0, aw_hs[i] & up_aw_atop_r_i[i]},
                               r_last_hs[i]);
            wcnt_d[i] = w_upd.cnt;
            rcnt_d[i] = r_upd.cnt;
            cnt_err   = cnt_err | w_upd.err | r_upd.err;
        end
    end

    always_comb begin
        drained = ~(|aw_pend_q) & ~(|ar_pend_q);
        for (int i = 0; i < NoSlvPorts; i++) begin
            if ((wcnt_q[i] != '0) || (rcnt_q[i] != '0)) begin
                drained = 1'b0;
            end
        end
    end

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the counter arrays steer the gating, so every element is
            // reset explicitly rather than treated as uninitialised storage.
            for (int i = 0; i < NoSlvPorts; i++) begin
                wcnt_q[i] <= '0;
                rcnt_q[i] <= '0;
            end
            aw_pend_q <= '0;
            ar_pend_q <= '0;
        end else begin
            for (int i = 0; i < NoSlvPorts; i++) begin
                wcnt_q[i] <= wcnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
            aw_pend_q <= xbar_aw_valid_o & ~xbar_aw_ready_i;
            ar_pend_q <= xbar_ar_valid_o & ~xbar_ar_ready_i;
        end
    end

    // -----------------------------------------------------------------------
    // Reconfiguration FSM (registered outputs)
    // -----------------------------------------------------------------------
`ifdef AXI_XBAR_CFG_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    logic [TmoW-1:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TimeoutCycles;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cfg_ready_q   <= 1'b1;
            shadow_en_q   <= '0;
            shadow_port_q <= '0;
            en_q          <= RstEnDefault;
            port_q        <= RstDefaultPort;
`ifdef AXI_XBAR_CFG_CTRL_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= err_q | cnt_err;
            case (state_q)
                StIdle: begin
                    if (cfg_valid_i) begin
                        shadow_en_q   <= cfg_en_default_i;
                        shadow_port_q <= cfg_default_port_i;
                        state_q       <= StDrain;
                        busy_q        <= 1'b1;
                        cfg_ready_q   <= 1'b0;
`ifdef AXI_XBAR_CFG_CTRL_TIMEOUT_EN
                        tmo_q         <= '0;
`endif
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q <= StApply;
                        done_q  <= 1'b1;
`ifdef AXI_XBAR_CFG_CTRL_TIMEOUT_EN
                    end else if (tmo_q == TmoLast) begin
                        // Give up: keep the old settings and flag the error.
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                StApply: begin
                    en_q        <= shadow_en_q;
                    port_q      <= shadow_port_q;
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o           = cfg_ready_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign err_o                 = err_q;
    assign en_default_mst_port_o = en_q;
    assign default_mst_port_o    = port_q;

endmodule
